beat_thresh_ctrl: RTL and testbench
===================================

// Module: beat_thresh_ctrl
// PURPOSE
//  Adaptive threshold scheduler for the beat tracker. Takes one band-energy value per FFT frame.
//  Keeps a sliding window of the last 2**LOG_FRAMES frame energies in a ring buffer.
//  Drives the tracker's 8-bit thresh input with a scaled, saturated running average.
//  Sits between the FFT/beat-energy stage and beat detection; replaces the static threshold switches.
// PARAMETERS
//  LOG_FRAMES  4   log2 of history depth (16 frames)
//  GAIN_Q2     6   threshold gain in Q2 fixed point (6 = 1.5x average)
//  THRESH_MIN  8   floor applied to the auto threshold
//  E_W         32  frame_energy width (signed)
// PORTS
//  clk            in   1    system clock
//  reset          in   1    synchronous, active-low reset (asserted when 0)
//  frame_valid    in   1    1-cycle pulse: frame_energy valid (one per FFT frame)
//  frame_energy   in   E_W  signed band energy of the frame
//  manual_en      in   1    1 = output manual_thresh instead of the auto value
//  manual_thresh  in   8    manual threshold
//  thresh         out  8    threshold to the beat tracker (registered)
//  thresh_valid   out  1    history full, or manual_en set
//  overrun        out  1    sticky: a frame arrived while busy and was dropped
//  frame_ctr      out  16   accepted-frame count, wraps at 2**16
// BEHAVIOUR
//  Reset values (reset==0 at a clk edge): thresh=8'hFF, thresh_valid=0, overrun=0, frame_ctr=0.
//   Internal: sum=0, wr_ptr=0, fill=0, state=TC_IDLE. RAM contents are not cleared.
//  FSM (one state per cycle):
//   TC_IDLE   -> TC_READ when frame_valid. Latch e = max(frame_energy,0). frame_ctr++.
//   TC_READ   -> TC_UPDATE. Registered RAM read of oldest = ram[wr_ptr].
//   TC_UPDATE -> TC_CALC. Operations:
//     - sum <= sum + e - (full ? oldest : 0)
//     - ram[wr_ptr] <= e
//     - wr_ptr++ (wraps mod 2**LOG_FRAMES)
//     - fill saturates at 2**LOG_FRAMES; full = (fill == 2**LOG_FRAMES)
//   TC_CALC   -> TC_IDLE. Register thresh_auto.
//  Latency: acceptance edge E0 -> thresh_auto registered at E3. Next frame is accepted at E4 or later.
//  Busy = state != TC_IDLE. If frame_valid is high while busy:
//   - the frame is dropped
//   - overrun <= 1 (cleared only by reset)
//   - frame_ctr is unchanged
//  Arithmetic:
//   - sum width E_W+LOG_FRAMES, unsigned, never wraps
//   - avg = sum >> LOG_FRAMES; always divides by the full window
//   - scaled = (avg*GAIN_Q2) >> 2, computed at full width
//   - thresh_auto = scaled>255 ? 255 : (scaled<THRESH_MIN ? THRESH_MIN : scaled[7:0])
//  Output register, updated every cycle:
//   - thresh <= manual_en ? manual_thresh : (full ? thresh_auto : 8'hFF)
//   - thresh_valid <= manual_en | full
//   - manual_en changes take effect 1 cycle later, even mid-update.
//  Warm-up: until fill reaches 2**LOG_FRAMES, thresh=8'hFF (no beats possible).
//   thresh_valid rises at the edge after TC_CALC of the 16th accepted frame.
//  Reset mid-operation: the FSM aborts to TC_IDLE; a partial update is discarded.
//   Stale RAM data is masked because fill=0.
//  Simultaneous frame_valid and reset: reset wins; the frame is not counted.
// STRUCTURE
//  Package atlas_beat_pkg holds:
//   - typedef enum logic [1:0] {TC_IDLE,TC_READ,TC_UPDATE,TC_CALC} thresh_ctrl_state
//   - localparam THRESH_W=8
//  Sub-module thresh_hist_ram: 2**LOG_FRAMES x E_W single-port RAM with registered read, no reset.
//  All other logic (FSM, sum, saturation, output mux) lives in this module.
// TESTING
//  1. 16 frames of e=100, spaced 10 cycles -> thresh_valid rises after the 16th;
//     thresh=150; frame_ctr=16; thresh=8'hFF before that.
//  2. Then 8 frames of e=200 -> avg=150, thresh=225. Then 8 more -> avg=200, thresh=255 (saturated).
//  3. Full window of e=0, and separately of e=-500 -> thresh=THRESH_MIN=8 (negatives clamped to 0).
//  4. frame_valid on 2 consecutive cycles -> second dropped; overrun=1 stays set;
//     frame_ctr +1 only; sum reflects one frame.
//  5. reset=0 during TC_UPDATE of frame 10 -> next cycle: thresh=8'hFF, thresh_valid=0, frame_ctr=0.
//     After 16 new frames of e=40 -> thresh=60, with no stale contribution.
//  6. manual_en=1, manual_thresh=33 mid-warm-up -> next cycle thresh=33, thresh_valid=1.
//     manual_en=0 -> returns to 8'hFF or the auto value.

Source files
------------

// File: rtl/atlas_beat_pkg.sv
// Shared types for the beat-tracker threshold controller.
package atlas_beat_pkg;

    typedef enum logic [1:0] {
        TC_IDLE,
        TC_READ,
        TC_UPDATE,
        TC_CALC
    } thresh_ctrl_state;

    localparam int THRESH_W = 8;

endpackage

// File: rtl/thresh_hist_ram.sv
// Frame-energy history: single-port RAM with registered read and no reset.
module thresh_hist_ram #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Read-before-write: rdata returns the old word when addr is written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/beat_thresh_ctrl.sv
// Adaptive beat threshold: 1.5x sliding-window average of frame energies,
// saturated to 8 bits, with manual override and warm-up masking.
module beat_thresh_ctrl
    import atlas_beat_pkg::*;
#(
    parameter int LOG_FRAMES = 4,
    parameter int GAIN_Q2    = 6,
    parameter int THRESH_MIN = 8,
    parameter int E_W        = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frame_valid,
    input  logic [E_W-1:0]      frame_energy,
    input  logic                manual_en,
    input  logic [THRESH_W-1:0] manual_thresh,
    output logic [THRESH_W-1:0] thresh,
    output logic                thresh_valid,
    output logic                overrun,
    output logic [15:0]         frame_ctr
);

    localparam int FRAMES = 2**LOG_FRAMES;
    localparam int SUM_W  = E_W + LOG_FRAMES;
    localparam int SCL_W  = E_W + 8;

    localparam logic [SCL_W-1:0]      GAIN_EXT = SCL_W'(GAIN_Q2);
    localparam logic [SCL_W-1:0]      SAT_MAX  = SCL_W'(2**THRESH_W - 1);
    localparam logic [SCL_W-1:0]      SAT_MIN  = SCL_W'(THRESH_MIN);
    localparam logic [LOG_FRAMES:0]   FILL_MAX = (LOG_FRAMES+1)'(FRAMES);

    thresh_ctrl_state state, state_nxt;

    logic signed [E_W-1:0]   energy_s;
    logic [E_W-1:0]          e_p0;
    logic [E_W-1:0]          oldest_p1;
    logic [SUM_W-1:0]        sum;
    logic [LOG_FRAMES-1:0]   wr_ptr;
    logic [LOG_FRAMES:0]     fill;
    logic                    full;
    logic [THRESH_W-1:0]     thresh_auto_p2;
    logic                    accept;
    logic                    ram_we;

    function automatic logic [E_W-1:0] clamp_pos(input logic signed [E_W-1:0] v);
        return (v < 0) ? '0 : E_W'(v);
    endfunction

    function automatic logic [THRESH_W-1:0] sat_thresh(input logic [SUM_W-1:0] s);
        logic [SCL_W-1:0] avg;
        logic [SCL_W-1:0] scaled;
        avg    = SCL_W'(s >> LOG_FRAMES);
        scaled = (avg * GAIN_EXT) >> 2;
        if (scaled > SAT_MAX) begin
            return '1;
        end else if (scaled < SAT_MIN) begin
            return THRESH_W'(THRESH_MIN);
        end
        return scaled[THRESH_W-1:0];
    endfunction

    assign energy_s = frame_energy;
    assign full     = (fill == FILL_MAX);
    assign ram_we   = (state == TC_UPDATE) && reset;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            TC_IDLE: begin
                if (frame_valid) begin
                    accept    = 1'b1;
                    state_nxt = TC_READ;
                end
            end
            TC_READ:   state_nxt = TC_UPDATE;
            TC_UPDATE: state_nxt = TC_CALC;
            TC_CALC:   state_nxt = TC_IDLE;
            default:   state_nxt = TC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= TC_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    thresh_hist_ram #(
        .ADDR_W (LOG_FRAMES),
        .DATA_W (E_W)
    ) u_hist (
        .clk   (clk),
        .we    (ram_we),
        .addr  (wr_ptr),
        .wdata (e_p0),
        .rdata (oldest_p1)
    );

    // p0: latch the clamped energy on acceptance
    always_ff @(posedge clk) begin
        if (accept) begin
            e_p0 <= clamp_pos(energy_s);
        end
    end

    // p1/p2: window sum and pointer bookkeeping, then the scaled threshold
    always_ff @(posedge clk) begin
        if (!reset) begin
            sum          <= '0;
            wr_ptr       <= '0;
            fill         <= '0;
            frame_ctr    <= '0;
            overrun      <= 1'b0;
            thresh       <= '1;
            thresh_valid <= 1'b0;
        end else begin
            if (accept) begin
                frame_ctr <= frame_ctr + 16'd1;
            end
            if (frame_valid && state != TC_IDLE) begin
                overrun <= 1'b1;
            end
            if (state == TC_UPDATE) begin
                sum    <= sum + SUM_W'(e_p0) - (full ? SUM_W'(oldest_p1) : '0);
                wr_ptr <= wr_ptr + 1'b1;
                if (!full) begin
                    fill <= fill + 1'b1;
                end
            end
            thresh       <= manual_en ? manual_thresh : (full ? thresh_auto_p2 : '1);
            thresh_valid <= manual_en | full;
        end
    end

    always_ff @(posedge clk) begin
        if (state == TC_CALC) begin
            thresh_auto_p2 <= sat_thresh(sum);
        end
    end

endmodule

// File: tb/tb_beat_thresh_ctrl.sv
// Bench for beat_thresh_ctrl: directed scenarios plus random energies checked
// against a window-of-frames reference model.
module tb_beat_thresh_ctrl;

    localparam int GAIN = 6;
    localparam int TMIN = 8;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               frame_valid = 1'b0;
    logic signed [31:0] frame_energy = '0;
    logic               manual_en = 1'b0;
    logic [7:0]         manual_thresh = '0;
    logic [7:0]         thresh;
    logic               thresh_valid;
    logic               overrun;
    logic [15:0]        frame_ctr;

    int total = 0;
    int bad   = 0;

    longint hist[$];
    int     m_ctr = 0;
    bit     m_ovr = 1'b0;

    always #5 clk = ~clk;

    beat_thresh_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .frame_valid   (frame_valid),
        .frame_energy  (frame_energy),
        .manual_en     (manual_en),
        .manual_thresh (manual_thresh),
        .thresh        (thresh),
        .thresh_valid  (thresh_valid),
        .overrun       (overrun),
        .frame_ctr     (frame_ctr)
    );

    function automatic logic [7:0] model_thresh();
        longint s = 0;
        longint sc;
        if (manual_en) return manual_thresh;
        if (hist.size() < 16) return 8'hFF;
        foreach (hist[i]) s += hist[i];
        sc = ((s / 16) * GAIN) / 4;
        if (sc > 255) return 8'd255;
        if (sc < TMIN) return 8'(TMIN);
        return sc[7:0];
    endfunction

    task automatic model_accept(input logic signed [31:0] e);
        hist.push_back((e < 0) ? 64'sd0 : longint'(e));
        if (hist.size() > 16) void'(hist.pop_front());
        m_ctr = (m_ctr + 1) % 65536;
    endtask

    task automatic model_reset();
        hist.delete();
        m_ctr = 0;
        m_ovr = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_thresh"}, 32'(thresh), 32'(model_thresh()));
        check({tag, "_valid"}, 32'(thresh_valid), 32'(manual_en | (hist.size() == 16)));
        check({tag, "_ctr"}, 32'(frame_ctr), 32'(m_ctr));
        check({tag, "_ovr"}, 32'(overrun), 32'(m_ovr));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        frame_valid = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        reset = 1'b1;
    endtask

    task automatic send_frame(input logic signed [31:0] e);
        @(negedge clk);
        frame_valid  = 1'b1;
        frame_energy = e;
        @(negedge clk);
        frame_valid  = 1'b0;
        model_accept(e);
        repeat (8) @(negedge clk);
    endtask

    function automatic logic signed [31:0] rand_energy();
        case ($urandom_range(0, 3))
            0:       return -$signed({1'b0, 31'($urandom_range(1, 100000))});
            1:       return $signed(32'($urandom_range(0, 300)));
            2:       return $signed(32'($urandom_range(0, 20000)));
            default: return $signed({1'b0, 31'($urandom())});
        endcase
    endfunction

    initial begin
        do_reset();
        reset = 1'b0;
        @(negedge clk);
        check("rst_thresh", 32'(thresh), 32'hFF);
        check("rst_valid", 32'(thresh_valid), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        check("rst_ctr", 32'(frame_ctr), 32'd0);
        reset = 1'b1;

        // Warm-up with e=100
        for (int i = 0; i < 16; i++) begin
            send_frame(32'sd100);
            if (i == 14) check_all("warm15");
        end
        check_all("t1");
        check("t1_abs", 32'(thresh), 32'd150);

        for (int i = 0; i < 8; i++) send_frame(32'sd200);
        check_all("t2a");
        check("t2a_abs", 32'(thresh), 32'd225);
        for (int i = 0; i < 8; i++) send_frame(32'sd200);
        check_all("t2b");
        check("t2b_abs", 32'(thresh), 32'd255);

        for (int i = 0; i < 16; i++) send_frame(32'sd0);
        check_all("t3_zero");
        for (int i = 0; i < 16; i++) send_frame(-32'sd500);
        check_all("t3_neg");
        check("t3_abs", 32'(thresh), 32'd8);

        // Back-to-back frames: second one lands in TC_READ and is dropped
        @(negedge clk);
        frame_valid  = 1'b1;
        frame_energy = 32'sd1000;
        @(negedge clk);
        model_accept(32'sd1000);
        frame_energy = 32'sd5000;
        @(negedge clk);
        frame_valid = 1'b0;
        m_ovr = 1'b1;
        repeat (8) @(negedge clk);
        check_all("t4");
        check("t4_abs", 32'(thresh), 32'd93);
        send_frame(32'sd0);
        check_all("t4_sticky");

        // Reset lands while frame 10 is in TC_UPDATE
        do_reset();
        for (int i = 0; i < 9; i++) send_frame(rand_energy());
        @(negedge clk);
        frame_valid  = 1'b1;
        frame_energy = 32'sd77777;
        @(negedge clk);
        frame_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        model_reset();
        check_all("t5_rst");
        reset = 1'b1;
        for (int i = 0; i < 16; i++) send_frame(32'sd40);
        check_all("t5");
        check("t5_abs", 32'(thresh), 32'd60);

        // Manual override mid-warm-up
        do_reset();
        for (int i = 0; i < 5; i++) send_frame(rand_energy());
        @(negedge clk);
        manual_en = 1'b1;
        manual_thresh = 8'd33;
        @(negedge clk);
        check_all("t6_on");
        send_frame(rand_energy());
        check_all("t6_hold");
        manual_en = 1'b0;
        @(negedge clk);
        check_all("t6_off");
        for (int i = 0; i < 10; i++) send_frame(rand_energy());
        check_all("t6_full");
        manual_en = 1'b1;
        manual_thresh = 8'($urandom_range(0, 255));
        @(negedge clk);
        check_all("t6_full_on");
        manual_en = 1'b0;
        @(negedge clk);
        check_all("t6_full_off");

        // Random sweep over the full window
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            send_frame(rand_energy());
            check_all("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
